instr_mem_sync: RTL and testbench

INSTR_MEM_SYNC -- requirements
Module: instr_mem_sync

---
 rtl/instr_mem_sync.sv | 140 ++++++++++++++
 tb/tb_instr_mem_sync.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_sync.sv
// Instruction memory with registered read, optional read wait states and a
// NOP-fill init sweep. Read-before-write on same-address load/response collisions.
module instr_mem_sync #(
    parameter int                 ADDR_W      = 8,
    parameter int                 DATA_W      = 32,
    parameter int                 WAIT_STATES = 0,
    parameter logic [DATA_W-1:0]  NOP_WORD    = DATA_W'(32'h0000_0013)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              init_start,
    output logic              init_busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] WAIT_LOAD =
        (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

    // IDLE: no work | WAIT: counting read latency | RESP: data out | INIT: NOP sweep
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        INIT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] iaddr_q, iaddr_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              can_start;
    logic              accept;
    logic              start_init;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign can_start   = (state_q == IDLE) || (state_q == RESP);
    assign fetch_ready = can_start && !init_start;
    assign accept      = fetch_ready && fetch_req;
    assign start_init  = can_start && init_start;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wcnt_d  = wcnt_q;
        iaddr_d = iaddr_q;
        rd_en   = 1'b0;
        rd_addr = addr_q;
        unique case (state_q)
            IDLE, RESP: begin
                if (start_init) begin
                    state_d = INIT;
                    iaddr_d = '0;
                end else if (accept) begin
                    addr_d = fetch_addr;
                    if (WAIT_STATES == 0) begin
                        // zero wait: read straight from the request address
                        state_d = RESP;
                        rd_en   = 1'b1;
                        rd_addr = fetch_addr;
                    end else begin
                        state_d = WAIT;
                        wcnt_d  = WAIT_LOAD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (wcnt_q == '0) begin
                    state_d = RESP;
                    rd_en   = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end
            INIT: begin
                iaddr_d = iaddr_q + 1'b1;
                if (iaddr_q == '1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign valid_d = rd_en;
    assign data_d  = rd_en ? mem[rd_addr] : data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wcnt_q  <= '0;
            iaddr_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wcnt_q  <= wcnt_d;
            iaddr_q <= iaddr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    // Memory is never cleared by reset; reset only suppresses the write.
    assign mem_we    = !rst && ((state_q == INIT) || load_we);
    assign mem_waddr = (state_q == INIT) ? iaddr_q  : load_addr;
    assign mem_wdata = (state_q == INIT) ? NOP_WORD : load_data;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign fetch_valid = valid_q;
    assign fetch_data  = data_q;
    assign init_busy   = (state_q == INIT);

endmodule

// File: tb/tb_instr_mem_sync.sv
// Directed bench for instr_mem_sync: instance a has no wait states, instance b
// has three; both use a 16-word memory so init sweeps stay short.
module tb_instr_mem_sync;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    int          checks   = 0;
    int          failures = 0;

    logic        req_a, ready_a, valid_a, we_a, init_a, busy_a;
    logic [3:0]  addr_a, laddr_a;
    logic [31:0] data_a, ldata_a;

    logic        req_b, ready_b, valid_b, we_b, init_b, busy_b;
    logic [3:0]  addr_b, laddr_b;
    logic [31:0] data_b, ldata_b;

    always #5 clk = ~clk;

    instr_mem_sync #(.ADDR_W(4), .DATA_W(32), .WAIT_STATES(0), .NOP_WORD(NOP)) dut_a (
        .clk(clk), .rst(rst),
        .fetch_req(req_a), .fetch_addr(addr_a), .fetch_ready(ready_a),
        .fetch_valid(valid_a), .fetch_data(data_a),
        .load_we(we_a), .load_addr(laddr_a), .load_data(ldata_a),
        .init_start(init_a), .init_busy(busy_a)
    );

    instr_mem_sync #(.ADDR_W(4), .DATA_W(32), .WAIT_STATES(3), .NOP_WORD(NOP)) dut_b (
        .clk(clk), .rst(rst),
        .fetch_req(req_b), .fetch_addr(addr_b), .fetch_ready(ready_b),
        .fetch_valid(valid_b), .fetch_data(data_b),
        .load_we(we_b), .load_addr(laddr_b), .load_data(ldata_b),
        .init_start(init_b), .init_busy(busy_b)
    );

    // Tasks are entered and left at a falling edge; inputs set there apply
    // to the next rising edge, outputs read there reflect the previous one.
    task automatic load_a(input logic [3:0] a, input logic [31:0] d);
        we_a = 1'b1; laddr_a = a; ldata_a = d;
        @(negedge clk);
        we_a = 1'b0;
    endtask

    task automatic load_b(input logic [3:0] a, input logic [31:0] d);
        we_b = 1'b1; laddr_b = a; ldata_b = d;
        @(negedge clk);
        we_b = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (valid_a !== 1'b0) begin failures++; $display("FAIL reset_valid_a: got %b expected 0", valid_a); end
        checks++; if (data_a !== 32'h0) begin failures++; $display("FAIL reset_data_a: got %h expected 00000000", data_a); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy_a: got %b expected 0", busy_a); end
        checks++; if (ready_a !== 1'b1) begin failures++; $display("FAIL reset_ready_a: got %b expected 1", ready_a); end
        checks++; if (valid_b !== 1'b0 || ready_b !== 1'b1) begin failures++; $display("FAIL reset_b: got valid=%b ready=%b expected valid=0 ready=1", valid_b, ready_b); end
    endtask

    task automatic test_load_fetch();
        load_a(4'd5, 32'hDEAD_BEEF);
        req_a = 1'b1; addr_a = 4'd5;
        #1;
        checks++; if (ready_a !== 1'b1) begin failures++; $display("FAIL lf_ready: got %b expected 1", ready_a); end
        @(negedge clk);
        req_a = 1'b0;
        checks++; if (valid_a !== 1'b1 || data_a !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lf_resp: got valid=%b data=%h expected valid=1 data=deadbeef", valid_a, data_a); end
        @(negedge clk);
        checks++; if (valid_a !== 1'b0 || data_a !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lf_hold: got valid=%b data=%h expected valid=0 data=deadbeef", valid_a, data_a); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w [3];
        w[0] = 32'hA0A0_0000; w[1] = 32'hB1B1_0001; w[2] = 32'hC2C2_0002;
        for (int i = 0; i < 3; i++) load_a(4'(i), w[i]);
        for (int i = 0; i <= 3; i++) begin
            if (i > 0) begin
                checks++;
                if (valid_a !== 1'b1 || data_a !== w[i-1] || ready_a !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_%0d: got valid=%b ready=%b data=%h expected valid=1 ready=1 data=%h", i-1, valid_a, ready_a, data_a, w[i-1]);
                end
            end
            if (i < 3) begin req_a = 1'b1; addr_a = 4'(i); end
            else req_a = 1'b0;
            @(negedge clk);
        end
        checks++; if (valid_a !== 1'b0) begin failures++; $display("FAIL b2b_end: got valid=%b expected 0", valid_a); end
    endtask

    task automatic test_same_edge();
        load_a(4'd7, 32'h2222_2222);
        req_a = 1'b1; addr_a = 4'd7;
        we_a = 1'b1; laddr_a = 4'd7; ldata_a = 32'h1111_1111;
        @(negedge clk);
        we_a = 1'b0;
        checks++; if (valid_a !== 1'b1 || data_a !== 32'h2222_2222) begin failures++; $display("FAIL rbw_old: got valid=%b data=%h expected valid=1 data=22222222", valid_a, data_a); end
        @(negedge clk);
        req_a = 1'b0;
        checks++; if (valid_a !== 1'b1 || data_a !== 32'h1111_1111) begin failures++; $display("FAIL rbw_new: got valid=%b data=%h expected valid=1 data=11111111", valid_a, data_a); end
        @(negedge clk);
    endtask

    task automatic test_wait_states();
        load_b(4'd5, 32'h5555_AAAA);
        req_b = 1'b1; addr_b = 4'd5;
        #1;
        checks++; if (ready_b !== 1'b1) begin failures++; $display("FAIL ws_accept_ready: got %b expected 1", ready_b); end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (valid_b !== 1'b0 || ready_b !== 1'b0) begin
                failures++;
                $display("FAIL ws_wait_%0d: got valid=%b ready=%b expected valid=0 ready=0", k, valid_b, ready_b);
            end
        end
        @(negedge clk);
        checks++; if (valid_b !== 1'b1 || data_b !== 32'h5555_AAAA || ready_b !== 1'b1) begin failures++; $display("FAIL ws_resp: got valid=%b ready=%b data=%h expected valid=1 ready=1 data=5555aaaa", valid_b, ready_b, data_b); end
        req_b = 1'b0;
        @(negedge clk);
        checks++; if (valid_b !== 1'b0 || data_b !== 32'h5555_AAAA) begin failures++; $display("FAIL ws_after: got valid=%b data=%h expected valid=0 data=5555aaaa", valid_b, data_b); end
    endtask

    task automatic test_reset_in_wait();
        int seen = 0;
        req_b = 1'b1; addr_b = 4'd5;
        @(negedge clk);
        req_b = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (data_b !== 32'h0) begin failures++; $display("FAIL rstwait_data: got %h expected 00000000", data_b); end
        for (int k = 0; k < 6; k++) begin
            if (valid_b === 1'b1) seen++;
            @(negedge clk);
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL rstwait_valid: got %0d valid cycles expected 0", seen); end
    endtask

    task automatic test_init();
        int busy_cnt = 0;
        int bad = 0;
        init_a = 1'b1; req_a = 1'b1; addr_a = 4'd1;
        #1;
        checks++; if (ready_a !== 1'b0) begin failures++; $display("FAIL init_ready_start: got %b expected 0", ready_a); end
        @(negedge clk);
        init_a = 1'b0; req_a = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (busy_a === 1'b1) busy_cnt++;
            if ((busy_a === 1'b1 && ready_a !== 1'b0) || valid_a === 1'b1) bad++;
            we_a = busy_a; laddr_a = 4'd3; ldata_a = 32'hFFFF_FFFF;
            @(negedge clk);
        end
        we_a = 1'b0;
        checks++; if (busy_cnt != 16) begin failures++; $display("FAIL init_busy_len: got %0d expected 16", busy_cnt); end
        checks++; if (bad != 0) begin failures++; $display("FAIL init_ready_valid: got %0d bad cycles expected 0", bad); end
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) begin
                checks++;
                if (valid_a !== 1'b1 || data_a !== NOP) begin
                    failures++;
                    $display("FAIL init_read_%0d: got valid=%b data=%h expected valid=1 data=%h", i-1, valid_a, data_a, NOP);
                end
            end
            if (i < 16) begin req_a = 1'b1; addr_a = 4'(i); end
            else req_a = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_init_reset();
        logic [31:0] exp_w [16];
        for (int i = 0; i < 16; i++) load_a(4'(i), 32'hC0DE_0000 + 32'(i));
        for (int i = 0; i < 16; i++) exp_w[i] = (i < 4) ? NOP : 32'hC0DE_0000 + 32'(i);
        init_a = 1'b1;
        @(negedge clk);
        init_a = 1'b0;
        for (int k = 1; k < 5; k++) @(negedge clk);
        checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL initrst_busy5: got %b expected 1", busy_a); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (busy_a !== 1'b0 || ready_a !== 1'b1 || valid_a !== 1'b0) begin failures++; $display("FAIL initrst_idle: got busy=%b ready=%b valid=%b expected busy=0 ready=1 valid=0", busy_a, ready_a, valid_a); end
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) begin
                checks++;
                if (valid_a !== 1'b1 || data_a !== exp_w[i-1]) begin
                    failures++;
                    $display("FAIL initrst_read_%0d: got valid=%b data=%h expected valid=1 data=%h", i-1, valid_a, data_a, exp_w[i-1]);
                end
            end
            if (i < 16) begin req_a = 1'b1; addr_a = 4'(i); end
            else req_a = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_a = 1'b0; addr_a = '0; we_a = 1'b0; laddr_a = '0; ldata_a = '0; init_a = 1'b0;
        req_b = 1'b0; addr_b = '0; we_b = 1'b0; laddr_b = '0; ldata_b = '0; init_b = 1'b0;
        @(negedge clk);
        test_reset();
        test_load_fetch();
        test_back_to_back();
        test_same_edge();
        test_wait_states();
        test_reset_in_wait();
        test_init();
        test_init_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
